// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the sequential ALU: operation encodings, FSM state
// enum, the mode of the iterative unit, ALUFlags bit positions, and a helper
// that assembles the {N,Z,C,V} flag vector.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  // Operation encodings on Op[2:0]
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ADC   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_SBC   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_ORR   = 3'b101;
  localparam logic [2:0] OP_UMULL = 3'b110;
  localparam logic [2:0] OP_UDIV  = 3'b111;

  // Controller states; Done is a registered pulse, not a state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Bit positions inside ALUFlags
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// -----------------------------------------------------------------------------
// alu_seq_iter
// Iterative datapath shared by unsigned multiply and unsigned divide. Holds a
// 2*WIDTH shift register {hi, lo}, the latched multiplicand/divisor, and one
// WIDTH+1 bit adder/subtractor with carry out.
//   MUL: hi starts at 0, lo holds the multiplier. Each step adds the
//        multiplicand to hi when lo[0]=1, then shifts the whole accumulator
//        (including the adder carry) right by one.
//   DIV: hi holds the partial remainder, lo the dividend bits still to be
//        consumed. Each step shifts left by one, trial-subtracts the divisor
//        and keeps the difference only when it does not borrow; the quotient
//        bit enters at lo[0].
// Ports
//   CLK, Reset  : clock, asynchronous active-high reset
//   load_i      : latch operands and clear the accumulator (highest priority)
//   div_i       : mode for load_i (0 = multiply, 1 = divide)
//   step_i      : perform one iteration
//   a_i, b_i    : operand A (multiplicand / dividend), B (multiplier / divisor)
//   acc_next_o  : accumulator value after the current step (product, or
//                 {remainder, quotient} once all steps are done)
// -----------------------------------------------------------------------------
module alu_seq_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 load_i,
  input  logic                 div_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_next_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH:0]     add_x, add_y, add_y_eff;
  logic [WIDTH+1:0]   add_ext;
  logic               no_borrow;
  logic [WIDTH-1:0]   rem_d;

  assign hi = acc_q[2*WIDTH-1:WIDTH];
  assign lo = acc_q[WIDTH-1:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    add_x     = '0;
    add_y     = '0;
    add_y_eff = '0;
    add_ext   = '0;
    no_borrow = 1'b0;
    rem_d     = '0;
    acc_d     = acc_q;

    // One shared adder: MUL adds opnd to hi, DIV subtracts opnd from the
    // left-shifted partial remainder {hi, lo[msb]} (WIDTH+1 bits wide).
    add_x     = div_q ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    add_y     = {1'b0, opnd_q};
    add_y_eff = div_q ? ~add_y : add_y;
    add_ext   = {1'b0, add_x} + {1'b0, add_y_eff} + {{(WIDTH+1){1'b0}}, div_q};

    if (div_q) begin
      // Carry out of the subtract means partial remainder >= divisor
      no_borrow = add_ext[WIDTH+1];
      rem_d     = no_borrow ? add_ext[WIDTH-1:0] : add_x[WIDTH-1:0];
      acc_d     = {rem_d, lo[WIDTH-2:0], no_borrow};
    end else begin
      // Shift right with the adder carry entering the top bit
      acc_d = lo[0] ? {add_ext[WIDTH:0], lo[WIDTH-1:1]}
                    : {1'b0, hi, lo[WIDTH-1:1]};
    end
  end

  assign acc_next_o = acc_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      div_q  <= div_i;
      opnd_q <= div_i ? b_i : a_i;
      acc_q  <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
    end else if (step_i) begin
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Multi-cycle ALU for the execute stage behind a Start/Busy/Done handshake.
// Single-cycle ops (ADD/ADC/SUB/SBC/AND/ORR) and divide-by-zero complete one
// cycle after Start. UMULL (full 2*WIDTH product) and UDIV (quotient and
// remainder) iterate WIDTH cycles in alu_seq_iter, with Busy high throughout.
// Outputs are registered and hold between Done pulses.
// Ports
//   CLK       : clock, rising edge
//   Reset     : asynchronous active-high reset
//   Start     : request, sampled only while Busy=0
//   Op        : operation select (see alu_seq_pkg)
//   Src_A     : operand A / dividend
//   Src_B     : operand B / divisor
//   CarryIn   : C flag input for ADC/SBC
//   Busy      : iterative operation in progress
//   Done      : one-cycle pulse, outputs updated this cycle
//   Result    : sum/difference/logic result, product low word, or quotient
//   ResultHi  : product high word or remainder; 0 for other ops
//   ALUFlags  : {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       ALUFlags
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic [3:0]         flags_q;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sc_result;
  logic             sc_c, sc_v;
  logic [3:0]       sc_flags;

  always_comb begin
    b_eff     = '0;
    cin_eff   = 1'b0;
    sum_ext   = '0;
    sc_result = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;

    // Op[1] selects subtract (inverted B); Op[0] selects CarryIn instead of
    // the fixed carry (0 for ADD, 1 for SUB).
    b_eff   = Op[1] ? ~Src_B : Src_B;
    cin_eff = Op[0] ? CarryIn : Op[1];
    sum_ext = {1'b0, Src_A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};

    if (Op[2] == 1'b0) begin
      sc_result = sum_ext[WIDTH-1:0];
      sc_c      = sum_ext[WIDTH];
      sc_v      = (Src_A[WIDTH-1] ~^ b_eff[WIDTH-1]) &
                  (Src_A[WIDTH-1] ^ sum_ext[WIDTH-1]);
    end else begin
      sc_result = Op[0] ? (Src_A | Src_B) : (Src_A & Src_B);
    end
  end

  assign sc_flags = pack_flags(sc_result[WIDTH-1], sc_result == '0, sc_c, sc_v);

  // ---------------------------------------------------------------------------
  // Iterative unit
  // ---------------------------------------------------------------------------
  logic               iter_load;
  logic               iter_step;
  logic [2*WIDTH-1:0] iter_acc_next;
  logic               last_step;

  assign iter_load = (state_q == ST_IDLE) && Start &&
                     ((Op == OP_UMULL) || ((Op == OP_UDIV) && (Src_B != '0)));
  assign iter_step = (state_q != ST_IDLE);
  assign last_step = (cnt_q == CNT_W'(1));

  alu_seq_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .CLK        (CLK),
    .Reset      (Reset),
    .load_i     (iter_load),
    .div_i      (Op[0]),
    .step_i     (iter_step),
    .a_i        (Src_A),
    .b_i        (Src_B),
    .acc_next_o (iter_acc_next)
  );

  // ---------------------------------------------------------------------------
  // Controller and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (Op[2:1] != 2'b11) begin
              result_q    <= sc_result;
              result_hi_q <= '0;
              flags_q     <= sc_flags;
              done_q      <= 1'b1;
            end else if (Op == OP_UMULL) begin
              state_q <= ST_MUL;
              cnt_q   <= CNT_W'(WIDTH);
              busy_q  <= 1'b1;
            end else if (Src_B == '0) begin
              // Divide by zero: saturated quotient, dividend as remainder
              result_q    <= '1;
              result_hi_q <= Src_A;
              flags_q     <= pack_flags(1'b1, 1'b0, 1'b0, 1'b1);
              done_q      <= 1'b1;
            end else begin
              state_q <= ST_DIV;
              cnt_q   <= CNT_W'(WIDTH);
              busy_q  <= 1'b1;
            end
          end
        end

        ST_MUL, ST_DIV: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_step) begin
            // Capture the value the final step produces, so Done lands in
            // the cycle right after the last Busy cycle.
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= iter_acc_next[WIDTH-1:0];
            result_hi_q <= iter_acc_next[2*WIDTH-1:WIDTH];
            if (state_q == ST_MUL) begin
              flags_q <= pack_flags(iter_acc_next[2*WIDTH-1],
                                    iter_acc_next == '0, 1'b0, 1'b0);
            end else begin
              flags_q <= pack_flags(iter_acc_next[WIDTH-1],
                                    iter_acc_next[WIDTH-1:0] == '0, 1'b0, 1'b0);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Result   = result_q;
  assign ResultHi = result_hi_q;
  assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq at WIDTH=32. Expected values come from
// directed constants and a behavioural model using plain 64-bit arithmetic
// (+, *, /, %, signed range checks). Inputs change on the falling edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [2:0]    Op = 3'b000;
  logic [W-1:0]  Src_A = '0;
  logic [W-1:0]  Src_B = '0;
  logic          CarryIn = 1'b0;
  logic          Busy, Done;
  logic [W-1:0]  Result, ResultHi;
  logic [3:0]    ALUFlags;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .Src_A    (Src_A),
    .Src_B    (Src_B),
    .CarryIn  (CarryIn),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .ResultHi (ResultHi),
    .ALUFlags (ALUFlags)
  );

  always #5 CLK = ~CLK;

  // Reference model: {Result, ResultHi, NZCV} and cycles from Start to Done
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, b,
                       input logic cin, output logic [2*W+3:0] exp,
                       output int lat);
    longint unsigned u;
    longint          s;
    logic [W-1:0]    bp, r, rh;
    logic            c0, n, z, c, v;
    r = '0; rh = '0; n = 0; z = 0; c = 0; v = 0; lat = 1;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        bp = op[1] ? ~b : b;
        c0 = op[0] ? cin : op[1];
        u  = {32'd0, a} + {32'd0, bp} + {63'd0, c0};
        s  = longint'($signed(a)) + longint'($signed(bp)) + longint'({63'd0, c0});
        r  = u[W-1:0];
        c  = u[W];
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        n  = r[W-1]; z = (r == 0);
      end
      OP_AND: begin r = a & b; n = r[W-1]; z = (r == 0); end
      OP_ORR: begin r = a | b; n = r[W-1]; z = (r == 0); end
      OP_UMULL: begin
        u = {32'd0, a} * {32'd0, b};
        r = u[W-1:0]; rh = u[2*W-1:W];
        n = u[2*W-1]; z = (u == 0); lat = W + 1;
      end
      default: begin
        if (b == 0) begin
          r = '1; rh = a; n = 1; v = 1;
        end else begin
          r = a / b; rh = a % b; n = r[W-1]; z = (r == 0); lat = W + 1;
        end
      end
    endcase
    exp = {r, rh, n, z, c, v};
  endtask

  // Issue one op (Start high for one cycle) and wait for Done, bounded.
  // Operands are scrambled after Start to show they are not resampled.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, b,
                       input logic cin, output int lat, output int busy_cnt,
                       output logic busy_at_done);
    @(negedge CLK);
    Start = 1'b1; Op = op; Src_A = a; Src_B = b; CarryIn = cin;
    @(negedge CLK);
    Start = 1'b0; Op = 3'($urandom); Src_A = $urandom; Src_B = $urandom;
    CarryIn = 1'($urandom);
    lat = 1; busy_cnt = 0;
    while (Done !== 1'b1 && lat < 60) begin
      if (Busy === 1'b1) busy_cnt++;
      @(negedge CLK);
      lat++;
    end
    busy_at_done = Busy;
    if (Done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if ({Busy, Done} !== 2'b00) begin
      failures++; $display("FAIL reset_handshake got=%b exp=00", {Busy, Done});
    end
    checks++;
    if ({Result, ResultHi, ALUFlags} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {Result, ResultHi, ALUFlags});
    end
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if ({Busy, Done, Result, ResultHi, ALUFlags} !== '0) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=0", {Busy, Done, Result, ResultHi, ALUFlags});
    end
  endtask

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic           cin;
    logic [2*W+3:0] exp;
  } vec_t;

  task automatic test_single_cycle();
    vec_t vecs[6];
    int lat, bc; logic bd;
    vecs[0] = '{OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, {32'h80000000, 32'h0, 4'b1001}};
    vecs[1] = '{OP_SUB, 32'd5, 32'd5, 1'b0, {32'h0, 32'h0, 4'b0110}};
    vecs[2] = '{OP_SBC, 32'd5, 32'd5, 1'b0, {32'hFFFFFFFF, 32'h0, 4'b1000}};
    vecs[3] = '{OP_ADC, 32'hFFFFFFFF, 32'h0, 1'b1, {32'h0, 32'h0, 4'b0110}};
    vecs[4] = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, {32'hF000F000, 32'h0, 4'b1000}};
    vecs[5] = '{OP_ORR, 32'h0, 32'h0, 1'b1, {32'h0, 32'h0, 4'b0100}};
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc, bd);
      checks++;
      if (lat != 1 || bc != 0 || bd !== 1'b0) begin
        failures++;
        $display("FAIL single_timing[%0d] got lat=%0d busy=%0d/%b exp lat=1 busy=0", i, lat, bc, bd);
      end
      checks++;
      if ({Result, ResultHi, ALUFlags} !== vecs[i].exp) begin
        failures++;
        $display("FAIL single_out[%0d] got=%h exp=%h", i, {Result, ResultHi, ALUFlags}, vecs[i].exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [2*W+3:0] held;
    held = {Result, ResultHi, ALUFlags};
    repeat (3) @(negedge CLK);
    checks++;
    if (Done !== 1'b0 || {Result, ResultHi, ALUFlags} !== held) begin
      failures++;
      $display("FAIL hold got done=%b out=%h exp done=0 out=%h", Done, {Result, ResultHi, ALUFlags}, held);
    end
  endtask

  task automatic test_umull();
    int lat, bc; logic bd;
    do_op(OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc, bd);
    checks++;
    if (lat != 33 || bc != 32 || bd !== 1'b0) begin
      failures++;
      $display("FAIL umull_timing got lat=%0d busy=%0d/%b exp lat=33 busy=32/0", lat, bc, bd);
    end
    checks++;
    if ({Result, ResultHi, ALUFlags} !== {32'h00000001, 32'hFFFFFFFE, 4'b1000}) begin
      failures++;
      $display("FAIL umull_max got=%h exp=%h", {Result, ResultHi, ALUFlags},
               {32'h00000001, 32'hFFFFFFFE, 4'b1000});
    end
  endtask

  task automatic test_udiv();
    vec_t vecs[4];
    int   lats[4];
    int   lat, bc; logic bd;
    vecs[0] = '{OP_UDIV, 32'd100, 32'd7, 1'b0, {32'd14, 32'd2, 4'b0000}};
    vecs[1] = '{OP_UDIV, 32'd9, 32'd0, 1'b0, {32'hFFFFFFFF, 32'd9, 4'b1001}};
    vecs[2] = '{OP_UDIV, 32'd3, 32'd10, 1'b0, {32'd0, 32'd3, 4'b0100}};
    vecs[3] = '{OP_UDIV, 32'hFFFFFFFF, 32'd1, 1'b0, {32'hFFFFFFFF, 32'd0, 4'b1000}};
    lats = '{33, 1, 33, 33};
    for (int i = 0; i < 4; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc, bd);
      checks++;
      if (lat != lats[i] || bc != lats[i] - 1) begin
        failures++;
        $display("FAIL udiv_timing[%0d] got lat=%0d busy=%0d exp lat=%0d", i, lat, bc, lats[i]);
      end
      checks++;
      if ({Result, ResultHi, ALUFlags} !== vecs[i].exp) begin
        failures++;
        $display("FAIL udiv_out[%0d] got=%h exp=%h", i, {Result, ResultHi, ALUFlags}, vecs[i].exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [2*W+3:0] exp, got;
    int lat, ndone, first;
    ndone = 0; first = -1; got = '0;
    model(OP_UMULL, 32'h12345678, 32'h9ABCDEF0, 1'b0, exp, lat);
    @(negedge CLK);
    Start = 1'b1; Op = OP_UMULL; Src_A = 32'h12345678; Src_B = 32'h9ABCDEF0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge CLK);
      if (Done === 1'b1) begin
        ndone++;
        if (first < 0) begin first = c; got = {Result, ResultHi, ALUFlags}; end
      end
      Start = (c == 5);
      if (c == 5) begin Op = OP_ADD; Src_A = 32'd1; Src_B = 32'd1; end
    end
    checks++;
    if (ndone != 1 || first != 33) begin
      failures++;
      $display("FAIL start_ignored_done got count=%0d at=%0d exp count=1 at=33", ndone, first);
    end
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL start_ignored_out got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, ndone; logic bd;
    ndone = 0;
    @(negedge CLK);
    Start = 1'b1; Op = OP_UDIV; Src_A = 32'd1000000; Src_B = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (Done === 1'b1) ndone++;
    end
    checks++;
    if (Busy !== 1'b1) begin
      failures++; $display("FAIL reset_mid_busy got=%b exp=1", Busy);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({Busy, Done, Result, ResultHi, ALUFlags} !== '0) begin
      failures++;
      $display("FAIL reset_mid_clear got=%h exp=0", {Busy, Done, Result, ResultHi, ALUFlags});
    end
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (Done === 1'b1 || Busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++; $display("FAIL reset_mid_nodone got=%0d exp=0", ndone);
    end
    do_op(OP_ADD, 32'd2, 32'd3, 1'b0, lat, bc, bd);
    checks++;
    if (lat != 1 || {Result, ResultHi, ALUFlags} !== {32'd5, 32'd0, 4'b0000}) begin
      failures++;
      $display("FAIL reset_mid_after got lat=%0d out=%h exp lat=1 out=%h", lat,
               {Result, ResultHi, ALUFlags}, {32'd5, 32'd0, 4'b0000});
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W+3:0] exp;
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic           cin;
    int lat, bc; logic bd;
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom; cin = 1'($urandom);
      if (i == 0) begin op = OP_SUB; a = 32'h80000000; b = 32'h1; end
      model(op, a, b, cin, exp, lat);
      Start = 1'b1; Op = op; Src_A = a; Src_B = b; CarryIn = cin;
      @(negedge CLK);
      checks++;
      if (Done !== 1'b1 || {Result, ResultHi, ALUFlags} !== exp) begin
        failures++;
        $display("FAIL b2b[%0d] op=%0d got done=%b out=%h exp=%h", i, op, Done,
                 {Result, ResultHi, ALUFlags}, exp);
      end
    end
    Start = 1'b0;
    // Start accepted in the Done cycle of an iterative op
    do_op(OP_UMULL, 32'd3, 32'd5, 1'b0, lat, bc, bd);
    Start = 1'b1; Op = OP_ORR; Src_A = 32'h00F0; Src_B = 32'h0F00;
    @(negedge CLK);
    Start = 1'b0;
    checks++;
    if (lat != 33 || Done !== 1'b1 || {Result, ResultHi, ALUFlags} !== {32'h0FF0, 32'h0, 4'b0000}) begin
      failures++;
      $display("FAIL b2b_after_mul got lat=%0d done=%b out=%h exp=%h", lat, Done,
               {Result, ResultHi, ALUFlags}, {32'h0FF0, 32'h0, 4'b0000});
    end
  endtask

  task automatic test_random();
    logic [2*W+3:0] exp;
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic           cin;
    int elat, lat, bc; logic bd;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      cin = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      model(op, a, b, cin, exp, elat);
      do_op(op, a, b, cin, lat, bc, bd);
      checks++;
      if (lat != elat || bc != elat - 1 || bd !== 1'b0) begin
        failures++;
        $display("FAIL rand_timing[%0d] op=%0d got lat=%0d busy=%0d exp lat=%0d", i, op, lat, bc, elat);
      end
      checks++;
      if ({Result, ResultHi, ALUFlags} !== exp) begin
        failures++;
        $display("FAIL rand_out[%0d] op=%0d a=%h b=%h cin=%b got=%h exp=%h", i, op, a, b, cin,
                 {Result, ResultHi, ALUFlags}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_hold();
    test_umull();
    test_udiv();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU that extends the datapath's single-cycle integer unit with iterative unsigned multiply (full 2×WIDTH product) and unsigned divide (quotient + remainder). It sits in the execute stage behind a Start/Busy/Done handshake. The pipeline stalls while Busy is high and captures Result, ResultHi and ALUFlags on Done. Single-cycle operations (add/sub/logic) go through the same handshake with one-cycle latency, so the stage controller handles a single protocol.

## Interface
- WIDTH, 32: operand and result width; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  3  operation: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 ORR, 110 UMULL, 111 UDIV.
- Src_A  in  WIDTH  operand A / dividend; sampled with Start.
- Src_B  in  WIDTH  operand B / divisor; sampled with Start.
- CarryIn  in  1  current C flag for ADC/SBC; sampled with Start.
- Busy  out  1  iterative operation in progress.
- Done  out  1  one-cycle pulse; Result, ResultHi and ALUFlags valid and updated this cycle.
- Result  out  WIDTH  sum, difference, logic result, product low word, or quotient.
- ResultHi  out  WIDTH  product high word or remainder; 0 for other ops.
- ALUFlags  out  4  {N,Z,C,V}.

## Operation
- States: IDLE, MUL, DIV. Done is a registered pulse, not a state.
- IDLE, Start=1, Op[2:1]≠11: compute in one cycle, register the outputs, pulse Done, stay in IDLE.
  - ADD: A+B. ADC: A+B+CarryIn. SUB: A+~B+1. SBC: A+~B+CarryIn.
  - Arithmetic ops use a WIDTH+1 sum. C is the carry out. V = (A[msb] ~^ B'[msb]) & (A[msb] ^ sum[msb]), where B' is the effective addend.
  - AND/ORR: C=0, V=0.
- IDLE, Start=1, Op=110: latch operands, clear the accumulator, count=WIDTH, go to MUL.
  - Each cycle: radix-2 shift-add on a 2×WIDTH accumulator, count−1.
  - At count=1: register the result, go to IDLE.
  - Result = product[WIDTH-1:0], ResultHi = product[2W-1:W].
  - N = product[2W-1]; Z = full product == 0; C=0, V=0.
- IDLE, Start=1, Op=111, Src_B≠0: go to DIV.
  - Restoring division, one quotient bit per cycle, WIDTH cycles.
  - Result = quotient, ResultHi = remainder.
  - N, Z from the quotient; C=0, V=0.
- IDLE, Start=1, Op=111, Src_B=0: no iteration.
  - Result = all-ones, ResultHi = Src_A, V=1, C=0, N=1, Z=0.
  - Done on the next cycle, as for single-cycle ops.
- Start while Busy=1 is ignored; operand changes during Busy have no effect.
- Result, ResultHi and ALUFlags hold between Done pulses.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Result=0, ResultHi=0, ALUFlags=0000, counter=0.
- Single-cycle ops and divide-by-zero:
  - Start in cycle n → Done=1 with new outputs in cycle n+1.
  - Busy never asserts.
- UMULL/UDIV:
  - Start in cycle n → Busy=1 in cycles n+1 … n+WIDTH.
  - Done=1 with outputs in cycle n+WIDTH+1; Busy=0 in that cycle.
- Back-to-back: Start is accepted in the Done cycle. Throughput is 1 op/cycle for single-cycle ops.
- Reset asserted mid-iteration: abandon the operation immediately and return all outputs to their reset values. No Done is issued for the abandoned op.
- Counter reaching 0 and a new Start cannot coincide, because Start is ignored while Busy=1.

## Structure
- Package alu_seq_pkg holds:
  - Op encodings: OP_ADD … OP_UDIV.
  - State enum: ST_IDLE, ST_MUL, ST_DIV.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_seq_iter holds the shared 2×WIDTH shift register and WIDTH+1 adder/subtractor. It is used by both MUL (add) and DIV (trial subtract).
- The top level keeps the FSM, counter, single-cycle datapath and output registers.

## Test plan
All cases at WIDTH=32.
- ADD 0x7FFFFFFF + 0x00000001, Start in cycle n → Done in n+1; Result 0x80000000; NZCV=1001; Busy stays 0.
- SUB 5 − 5 → Result 0, NZCV=0110. Then SBC 5 − 5 with CarryIn=0 → Result 0xFFFFFFFF, NZCV=1000.
- UMULL 0xFFFFFFFF × 0xFFFFFFFF → Busy cycles n+1…n+32; Done in n+33; ResultHi 0xFFFFFFFE, Result 0x00000001; NZCV=1000.
- UDIV 100 / 7 → Done in n+33; Result 14, ResultHi 2. UDIV 9 / 0 → Done in n+1; Result 0xFFFFFFFF, ResultHi 9; NZCV=1001.
- Start UMULL, then pulse Start with ADD at n+5 → ADD is ignored; one Done at n+33 with the product only.
- Start UDIV, assert Reset at n+10 → all outputs 0 immediately; no Done. A new ADD after Reset is released completes normally in 1 cycle.
